serial_data_rx: RTL

Synthesizable deserializer that sits directly downstream of the testbench serial generator. It oversamples an external serial clock/data pair in the system clock domain and assembles `DATA_WIDTH`-bit words. Each completed word is presented with a one-cycle valid strobe. A stalled partial frame is discarded on an idle timeout and flagged as an error, which keeps the receiver frame-aligned after glitches or truncated transfers.

---
 rtl/serial_data_rx.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_data_rx.sv
// rtl/serial_data_rx.sv - oversampling serial clock/data deserializer with idle-timeout frame abort
module serial_data_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter bit SAMPLE_EDGE    = 1'b0,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  ser_clk,
    input  logic                  ser_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state, next_state;
    logic [SYNC_STAGES-1:0]  clk_sync, data_sync;
    logic                    clk_prev;
    logic                    edge_det, edge_q, bit_q;
    logic [DATA_WIDTH-1:0]   shreg, shift_next;
    logic [CW-1:0]           bit_cnt;
    logic [TW-1:0]           tmo_cnt;
    logic                    sample, last_bit, timed_out;
    logic                    load_word, abort_err;

    // Synchronizers idle high to match the generator's idle level, so reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            edge_q    <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ser_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            edge_q    <= edge_det;
            bit_q     <= data_sync[SYNC_STAGES-1];
        end
    end

    assign edge_det = SAMPLE_EDGE ? (clk_sync[SYNC_STAGES-1] & ~clk_prev)
                                  : (~clk_sync[SYNC_STAGES-1] & clk_prev);

    assign sample     = edge_q & enable;
    assign last_bit   = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign timed_out  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign shift_next = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], bit_q}
                                  : {bit_q, shreg[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (sample) next_state = SHIFT;
            SHIFT: begin
                if (!enable)                    next_state = IDLE;
                else if (sample && last_bit)    next_state = IDLE;
                else if (!sample && timed_out)  next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SHIFT);
        load_word = (state == SHIFT) && sample && last_bit;
        abort_err = (state == SHIFT) && enable && !sample && timed_out;
    end

    // Datapath is cleared whenever the FSM heads to IDLE, which discards partial words on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= load_word;
            frame_err  <= abort_err;
            if (load_word) data_out <= shift_next;
            if (next_state == IDLE) begin
                shreg   <= '0;
                bit_cnt <= '0;
                tmo_cnt <= '0;
            end else if (sample) begin
                shreg   <= shift_next;
                bit_cnt <= bit_cnt + CW'(1);
                tmo_cnt <= '0;
            end else if (!timed_out) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule
